// File: rtl/mag_sort_ctrl_if.sv
// Load/drain stream bundle for mag_sort_ctrl: valid/ready word input and sorted word output.
interface mag_sort_ctrl_if #(
   parameter int unsigned WIDTH = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/mag_sort_ctrl.sv
// Bubble-sort controller time-sharing one magnitude_comparator over a DEPTH-word buffer.
// Optional macro MAG_SORT_EARLY_EXIT_EN ends SORT after the first swap-free pass.

module magnitude_comparator #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_lt_b
);
   assign a_gt_b = (a > b);
   assign a_eq_b = (a == b);
   assign a_lt_b = (a < b);
endmodule

module mag_sort_ctrl #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mag_sort_ctrl_if.slave       bus,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           swap_cnt
);
   localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SORT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] mem_nxt [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] j;
   logic [PTR_W-1:0] j_nxt;
   logic [PTR_W-1:0] pass;

   logic [WIDTH-1:0] cmp_a;
   logic [WIDTH-1:0] cmp_b;
   logic             cmp_gt;
   logic             cmp_eq;
   logic             cmp_lt;
   logic             swap_c;
   logic             load_c;
   logic             last_cmp_c;
   logic             early_c;
   logic             sort_end_c;

   magnitude_comparator #(.WIDTH(WIDTH)) u_cmp (
      .a      (cmp_a),
      .b      (cmp_b),
      .a_gt_b (cmp_gt),
      .a_eq_b (cmp_eq),
      .a_lt_b (cmp_lt)
   );

   // Adjacent-pair compare; equal words never swap, which keeps the sort stable.
   always_comb begin
      j_nxt      = j + PTR_W'(1);
      cmp_a      = mem[j];
      cmp_b      = mem[j_nxt];
      load_c     = (state == S_IDLE) && bus.in_valid && bus.in_ready;
      swap_c     = (state == S_SORT) && cmp_gt && !cmp_eq && !cmp_lt;
      last_cmp_c = (j == PTR_W'(DEPTH - 2));
      sort_end_c = last_cmp_c && ((pass == PTR_W'(DEPTH - 2)) || early_c);
   end

`ifdef MAG_SORT_EARLY_EXIT_EN
   logic pass_swapped;

   assign early_c = !(pass_swapped || swap_c);

   // Tracks whether the pass in progress has swapped anything yet.
   always_ff @(posedge clk) begin
      if (reset) begin
         pass_swapped <= 1'b0;
      end else if (state != S_SORT || last_cmp_c) begin
         pass_swapped <= 1'b0;
      end else if (swap_c) begin
         pass_swapped <= 1'b1;
      end
   end
`else
   assign early_c = 1'b0;
`endif

   // Next buffer contents: load write or adjacent swap.
   always_comb begin
      mem_nxt = mem;
      if (load_c) begin
         mem_nxt[wr_ptr] = bus.in_data;
      end
      if (swap_c) begin
         mem_nxt[j]     = mem[j_nxt];
         mem_nxt[j_nxt] = mem[j];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         mem <= mem_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         j             <= '0;
         pass          <= '0;
         swap_cnt      <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load_c) begin
                  if (wr_ptr == PTR_W'(DEPTH - 1)) begin
                     state        <= S_SORT;
                     wr_ptr       <= '0;
                     swap_cnt     <= '0;
                     pass         <= '0;
                     j            <= '0;
                     bus.in_ready <= 1'b0;
                     busy         <= 1'b1;
                  end else begin
                     wr_ptr <= wr_ptr + PTR_W'(1);
                  end
               end
            end

            S_SORT: begin
               if (swap_c && (swap_cnt != 8'hFF)) begin
                  swap_cnt <= swap_cnt + 8'd1;
               end
               if (sort_end_c) begin
                  state         <= S_DRAIN;
                  j             <= '0;
                  pass          <= '0;
                  rd_ptr        <= '0;
                  bus.out_valid <= 1'b1;
                  bus.out_data  <= mem_nxt[0];
               end else if (last_cmp_c) begin
                  j    <= '0;
                  pass <= pass + PTR_W'(1);
               end else begin
                  j <= j_nxt;
               end
            end

            S_DRAIN: begin
               if (bus.out_valid && bus.out_ready) begin
                  if (rd_ptr == PTR_W'(DEPTH - 1)) begin
                     state         <= S_IDLE;
                     rd_ptr        <= '0;
                     bus.out_valid <= 1'b0;
                     bus.in_ready  <= 1'b1;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                  end else begin
                     rd_ptr       <= rd_ptr + PTR_W'(1);
                     bus.out_data <= mem[rd_ptr + PTR_W'(1)];
                  end
               end
            end

            default: begin
               state         <= S_IDLE;
               bus.in_ready  <= 1'b1;
               bus.out_valid <= 1'b0;
               busy          <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mag_sort_ctrl.sv
// Self-checking bench for mag_sort_ctrl: vector table, expected-word scoreboard, stall and reset sequences.
module tb_mag_sort_ctrl;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 4;
`ifdef MAG_SORT_EARLY_EXIT_EN
   localparam int SORTED_CYC = 3;
`else
   localparam int SORTED_CYC = 9;
`endif

   typedef struct packed {
      logic [15:0] din;
      logic [15:0] dout;
      logic [7:0]  swaps;
      logic [7:0]  cyc;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       busy;
   logic       done;
   logic [7:0] swap_cnt;

   mag_sort_ctrl_if #(.WIDTH(WIDTH)) bus ();

   mag_sort_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .swap_cnt (swap_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         pass_cnt = 0;
   int         chk_cnt  = 0;
   vec_t       tbl [4];
   logic [3:0] exp_q [$];

   function automatic logic [15:0] w4(input int a, input int b, input int c, input int d);
      return {4'(d), 4'(c), 4'(b), 4'(a)};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic push_exp(input vec_t v);
      for (int k = 0; k < 4; k++) exp_q.push_back(v.dout[4*k +: 4]);
   endtask

   // Starts and ends on a negedge; words are presented there and accepted at the following posedge.
   task automatic load(input vec_t v);
      for (int k = 0; k < 4; k++) begin
         int t;
         bus.in_valid = 1'b1;
         bus.in_data  = v.din[4*k +: 4];
         t = 0;
         while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) begin
            chk_cnt++;
            $display("FAIL load_timeout: in_ready low for %0d cycles, required 1", t);
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic sort_and_drain(input string nm, input vec_t v, input int stall);
      int cyc, t, got, st;
      logic [3:0] head;
      cyc = 0;
      t   = 0;
      chk({nm, "_busy_sort"}, 32'(busy), 1);
      chk({nm, "_in_ready_sort"}, 32'(bus.in_ready), 0);
      while (!bus.out_valid && t < 100) begin
         if (busy) cyc++;
         @(negedge clk);
         t++;
      end
      chk({nm, "_sort_cycles"}, cyc, int'(v.cyc));
      got = 0;
      t   = 0;
      st  = stall;
      while (got < 4 && t < 200) begin
         if (st > 0) begin
            bus.out_ready = 1'b0;
            head = (exp_q.size() > 0) ? exp_q[0] : 4'hx;
            chk({nm, "_stall_valid"}, 32'(bus.out_valid), 1);
            chk({nm, "_stall_data"}, 32'(bus.out_data), 32'(head));
            st--;
         end else begin
            bus.out_ready = 1'b1;
            if (bus.out_valid) begin
               if (exp_q.size() == 0) begin
                  chk_cnt++;
                  $display("FAIL %s_scoreboard: got word %0d, required no word", nm, bus.out_data);
               end else begin
                  chk({nm, "_out_data"}, 32'(bus.out_data), 32'(exp_q.pop_front()));
               end
               chk({nm, "_done_early"}, 32'(done), 0);
               got++;
            end
         end
         @(negedge clk);
         t++;
      end
      if (got < 4) begin
         chk_cnt++;
         $display("FAIL %s_drain_timeout: got %0d words, required 4", nm, got);
      end
      chk({nm, "_done"}, 32'(done), 1);
      chk({nm, "_in_ready_done"}, 32'(bus.in_ready), 1);
      chk({nm, "_busy_idle"}, 32'(busy), 0);
      chk({nm, "_out_valid_idle"}, 32'(bus.out_valid), 0);
      chk({nm, "_swap_cnt"}, 32'(swap_cnt), int'(v.swaps));
      @(negedge clk);
      chk({nm, "_done_pulse"}, 32'(done), 0);
      chk({nm, "_swap_hold"}, 32'(swap_cnt), int'(v.swaps));
   endtask

   task automatic run_batch(input string nm, input vec_t v, input int stall);
      push_exp(v);
      load(v);
      sort_and_drain(nm, v, stall);
   endtask

   initial begin
      tbl[0] = '{din: w4(9, 15, 0, 5),  dout: w4(0, 5, 9, 15),   swaps: 8'd4, cyc: 8'd9};
      tbl[1] = '{din: w4(0, 1, 2, 3),   dout: w4(0, 1, 2, 3),    swaps: 8'd0, cyc: 8'(SORTED_CYC)};
      tbl[2] = '{din: w4(15, 12, 8, 0), dout: w4(0, 8, 12, 15),  swaps: 8'd6, cyc: 8'd9};
      tbl[3] = '{din: w4(15, 15, 0, 0), dout: w4(0, 0, 15, 15),  swaps: 8'd4, cyc: 8'd9};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_swap_cnt", 32'(swap_cnt), 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         run_batch($sformatf("vec%0d", i), tbl[i], 0);
      end

      run_batch("stall", tbl[0], 5);

      // Reset in the middle of SORT discards the batch without a done pulse.
      push_exp(tbl[2]);
      load(tbl[2]);
      repeat (3) @(negedge clk);
      chk("mid_busy", 32'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_out_data", 32'(bus.out_data), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_swap_cnt", 32'(swap_cnt), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("mid_rst_no_done", 32'(done), 0);
      end

      run_batch("fresh", tbl[3], 0);
      run_batch("fresh2", tbl[0], 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
